egress_pkt_switch: RTL and testbench
====================================

Name: egress_pkt_switch

Overview:
Parametrised successor of the single-beat egress switch. It buffers VNP4 pipeline output in a FIFO and routes whole packets to NUM_PHYS_FUNC PF and NUM_CMAC_PORT CMAC AXI-Stream masters. The route is locked per packet and multicast is supported. Packets with an empty route are dropped and counted. Sits between the VNP4 core and the QDMA/CMAC adapters in the 250 MHz shared TX/RX plugin.

Parameters:
NUM_PHYS_FUNC, 1, PF master count (1..4)
NUM_CMAC_PORT, 1, CMAC master count (1..10)
FIFO_DEPTH, 4, input FIFO depth in beats; power of two, >=2
CNT_W, 32, packet counter width

Ports:
aclk  in  1  clock
areset  in  1  asynchronous reset, active-high
s_axis  axi_stream_vnp4_if.slave  intf  input beats; user_dst_pf 4b, user_dst_cmac 10b, user_src_* same widths
m_axis_pf[NUM_PHYS_FUNC]  axi_stream_if.master  intf  PF outputs; user_src/user_dst 16b
m_axis_cmac[NUM_CMAC_PORT]  axi_stream_if.master  intf  CMAC outputs
cnt_clear  in  1  synchronous clear of both counters
fwd_pkt_cnt  out  CNT_W  packets forwarded (saturating)
drop_pkt_cnt  out  CNT_W  packets dropped (saturating)
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async assert, sync release to aclk): clears FIFO pointers, fifo_level, in_pkt, route_q, done mask and counters. All m_axis_*.valid=0. s_axis.ready=0 while areset=1. FIFO data storage is not reset.
- Input: s_axis.ready = !areset && (fifo_level < FIFO_DEPTH). This is registered state only, with no combinational path from the m_axis ready signals.
- Beat with valid && user_valid: pushed with data, keep, last and all user fields.
- Beat with valid && !user_valid: handshaken and discarded; nothing is pushed.
- At full, ready=0 even if a pop happens that same cycle.
- Latency: a beat accepted in cycle N is visible at the FIFO head in cycle N+1. Throughput is 1 beat/cycle when all selected outputs are ready.
- Route decode at head:
  - pf_mask = is_pf(user_to_direction) ? user_dst_pf[NUM_PHYS_FUNC-1:0] : 0
  - cmac_mask = is_cmac(user_to_direction) ? user_dst_cmac[NUM_CMAC_PORT-1:0] : 0
  - route = {cmac_mask, pf_mask}. Bits at or above the port counts are ignored.
- Packet lock: while in_pkt=0, the route is decoded from the head beat. while in_pkt=1, route_q is used and head user fields are ignored.
  - Pop of a non-last beat sets in_pkt and latches route_q.
  - Pop of a last beat clears in_pkt.
- Multicast fork: m_axis_X[i].valid = head_valid && route[i] && !done[i]. done[i] sets on valid && ready.
  - The head pops in the cycle where route & ~(done | fire) == 0; done clears on that pop.
  - Outputs that already took the beat stay low until the next beat. Data and user fields are held stable while any valid is high.
- Output fields: data, keep, last and user_size come from the head. user_src = {user_src_cmac, 2'b0, user_src_pf}; user_dst = {user_dst_cmac, 2'b0, user_dst_pf}.
- Drop: route==0 means the head pops every cycle with no output valid. drop_pkt_cnt increments on pop of the last beat.
- fwd_pkt_cnt increments on pop of a last beat with route!=0.
- Counters saturate at all-ones. cnt_clear has priority over a coincident increment (result 0).
- Boundaries:
  - Single-beat packets (last on first beat) never set in_pkt.
  - Simultaneous push and pop below full leaves fifo_level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset mid-packet: the partial packet is lost. Downstream may observe a truncated packet without last; this is accepted behaviour.

Test Plan:
- Reset then idle -> all valids 0, s_axis.ready=1 on the first cycle after release, counters 0, fifo_level=0.
- 3-beat packet, direction PF, dst_pf=4'b0001, all ready -> m_axis_pf[0] sees 3 beats with last on beat 3, first valid 1 cycle after first accept, fwd_pkt_cnt=1.
- NUM_PHYS_FUNC=2, NUM_CMAC_PORT=2; packet with dst_pf=4'b0010, then beat 2 carries dst_pf=4'b0001 -> all beats go only to pf[1] (lock holds).
- Multicast direction PF|CMAC, dst_pf=1, dst_cmac=1; pf[0] ready, cmac[0] ready held low 5 cycles -> pf[0] takes the beat once. cmac[0] gets it after ready rises. Head pops only then. FIFO fills to 4 and s_axis.ready drops.
- dst_pf=4'b1000 with NUM_PHYS_FUNC=1, 2-beat packet -> no output valid, drained in 2 cycles, drop_pkt_cnt=1.
- Back-to-back 1-beat packets with all outputs ready -> 1 beat/cycle, fifo_level stays <=1. cnt_clear coincident with a last pop -> counter reads 0.

Source files
------------

// File: rtl/egress_pkt_switch_if.sv
// rtl/egress_pkt_switch_if.sv - AXI-Stream interfaces used by the egress packet switch
// user_to_direction: bit 0 selects the PF side, bit 1 selects the CMAC side.
interface axi_stream_vnp4_if;
    logic        valid;
    logic        ready;
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        user_valid;
    logic [15:0] user_size;
    logic [3:0]  user_src_pf;
    logic [3:0]  user_dst_pf;
    logic [9:0]  user_src_cmac;
    logic [9:0]  user_dst_cmac;
    logic [1:0]  user_to_direction;

    modport master (
        output valid, data, keep, last, user_valid, user_size,
               user_src_pf, user_dst_pf, user_src_cmac, user_dst_cmac, user_to_direction,
        input  ready
    );
    modport slave (
        input  valid, data, keep, last, user_valid, user_size,
               user_src_pf, user_dst_pf, user_src_cmac, user_dst_cmac, user_to_direction,
        output ready
    );
endinterface

interface axi_stream_if;
    logic        valid;
    logic        ready;
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic [15:0] user_size;
    logic [15:0] user_src;
    logic [15:0] user_dst;

    modport master (
        output valid, data, keep, last, user_size, user_src, user_dst,
        input  ready
    );
    modport slave (
        input  valid, data, keep, last, user_size, user_src, user_dst,
        output ready
    );
endinterface

// File: rtl/egress_pkt_switch.sv
// rtl/egress_pkt_switch.sv - FIFO-buffered egress switch routing whole packets to PF/CMAC masters
// Route is locked for the packet duration; multicast forks each beat until every target took it.
module egress_pkt_switch #(
    parameter int NUM_PHYS_FUNC = 1,
    parameter int NUM_CMAC_PORT = 1,
    parameter int FIFO_DEPTH    = 4,
    parameter int CNT_W         = 32
) (
    input  logic                         aclk,
    input  logic                         areset,
    axi_stream_vnp4_if.slave             s_axis,
    axi_stream_if.master                 m_axis_pf   [NUM_PHYS_FUNC],
    axi_stream_if.master                 m_axis_cmac [NUM_CMAC_PORT],
    input  logic                         cnt_clear,
    output logic [CNT_W-1:0]             fwd_pkt_cnt,
    output logic [CNT_W-1:0]             drop_pkt_cnt,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NR = NUM_PHYS_FUNC + NUM_CMAC_PORT;
    localparam logic [AW:0] LVL_FULL = (AW+1)'(FIFO_DEPTH);
    localparam int DIR_PF_BIT   = 0;
    localparam int DIR_CMAC_BIT = 1;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic [15:0] user_size;
        logic [3:0]  src_pf;
        logic [3:0]  dst_pf;
        logic [9:0]  src_cmac;
        logic [9:0]  dst_cmac;
        logic [1:0]  dir;
    } beat_t;

    typedef enum logic {ST_IDLE, ST_IN_PKT} state_t;

    beat_t                    mem [FIFO_DEPTH];
    beat_t                    in_beat;
    beat_t                    head;
    logic [AW-1:0]            wr_ptr;
    logic [AW-1:0]            rd_ptr;
    logic                     push;
    logic                     pop;
    logic                     head_valid;
    state_t                   state;
    state_t                   state_next;
    logic [NR-1:0]            route_now;
    logic [NR-1:0]            route_q;
    logic [NR-1:0]            route;
    logic [NR-1:0]            done;
    logic [NR-1:0]            out_valid;
    logic [NR-1:0]            out_ready;
    logic [NR-1:0]            fire;
    logic [NUM_PHYS_FUNC-1:0] pf_mask;
    logic [NUM_CMAC_PORT-1:0] cmac_mask;
    logic                     pkt_end;

    // Ready depends only on registered occupancy, never on downstream ready.
    assign s_axis.ready = !areset && (fifo_level < LVL_FULL);
    assign push         = s_axis.valid && s_axis.ready && s_axis.user_valid;

    assign in_beat = '{
        data:      s_axis.data,
        keep:      s_axis.keep,
        last:      s_axis.last,
        user_size: s_axis.user_size,
        src_pf:    s_axis.user_src_pf,
        dst_pf:    s_axis.user_dst_pf,
        src_cmac:  s_axis.user_src_cmac,
        dst_cmac:  s_axis.user_dst_cmac,
        dir:       s_axis.user_to_direction
    };

    always_ff @(posedge aclk) begin
        if (push) begin
            mem[wr_ptr] <= in_beat;
        end
    end

    assign head       = mem[rd_ptr];
    assign head_valid = (fifo_level != '0);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + (AW+1)'(1);
                2'b01:   fifo_level <= fifo_level - (AW+1)'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    assign pf_mask   = head.dir[DIR_PF_BIT]   ? head.dst_pf[NUM_PHYS_FUNC-1:0]   : '0;
    assign cmac_mask = head.dir[DIR_CMAC_BIT] ? head.dst_cmac[NUM_CMAC_PORT-1:0] : '0;
    assign route_now = {cmac_mask, pf_mask};
    assign route     = (state == ST_IN_PKT) ? route_q : route_now;

    assign out_valid = {NR{head_valid}} & route & ~done;
    assign fire      = out_valid & out_ready;
    // An empty route pops immediately, which is how dropped packets drain.
    assign pop       = head_valid && ((route & ~(done | fire)) == '0);
    assign pkt_end   = pop && head.last;

    always_comb begin
        state_next = state;
        if (pop) begin
            state_next = head.last ? ST_IDLE : ST_IN_PKT;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state   <= ST_IDLE;
            route_q <= '0;
            done    <= '0;
        end else begin
            state <= state_next;
            if (pop && !head.last) route_q <= route;
            done <= pop ? '0 : (done | fire);
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            fwd_pkt_cnt  <= '0;
            drop_pkt_cnt <= '0;
        end else begin
            if (cnt_clear) begin
                fwd_pkt_cnt <= '0;
            end else if (pkt_end && (route != '0) && !(&fwd_pkt_cnt)) begin
                fwd_pkt_cnt <= fwd_pkt_cnt + CNT_W'(1);
            end
            if (cnt_clear) begin
                drop_pkt_cnt <= '0;
            end else if (pkt_end && (route == '0) && !(&drop_pkt_cnt)) begin
                drop_pkt_cnt <= drop_pkt_cnt + CNT_W'(1);
            end
        end
    end

    for (genvar i = 0; i < NUM_PHYS_FUNC; i++) begin : g_pf
        assign m_axis_pf[i].valid     = out_valid[i];
        assign m_axis_pf[i].data      = head.data;
        assign m_axis_pf[i].keep      = head.keep;
        assign m_axis_pf[i].last      = head.last;
        assign m_axis_pf[i].user_size = head.user_size;
        assign m_axis_pf[i].user_src  = {head.src_cmac, 2'b00, head.src_pf};
        assign m_axis_pf[i].user_dst  = {head.dst_cmac, 2'b00, head.dst_pf};
        assign out_ready[i]           = m_axis_pf[i].ready;
    end

    for (genvar i = 0; i < NUM_CMAC_PORT; i++) begin : g_cmac
        assign m_axis_cmac[i].valid     = out_valid[NUM_PHYS_FUNC+i];
        assign m_axis_cmac[i].data      = head.data;
        assign m_axis_cmac[i].keep      = head.keep;
        assign m_axis_cmac[i].last      = head.last;
        assign m_axis_cmac[i].user_size = head.user_size;
        assign m_axis_cmac[i].user_src  = {head.src_cmac, 2'b00, head.src_pf};
        assign m_axis_cmac[i].user_dst  = {head.dst_cmac, 2'b00, head.dst_pf};
        assign out_ready[NUM_PHYS_FUNC+i] = m_axis_cmac[i].ready;
    end
endmodule

// File: tb/tb_egress_pkt_switch.sv
// tb/tb_egress_pkt_switch.sv - directed self-checking bench for egress_pkt_switch
module tb_egress_pkt_switch;
    localparam int NPF   = 2;
    localparam int NCM   = 2;
    localparam int DEPTH = 4;
    localparam int CW    = 3;
    localparam logic [1:0] DIR_PF   = 2'b01;
    localparam logic [1:0] DIR_BOTH = 2'b11;

    logic          aclk = 1'b0;
    logic          areset;
    logic          cnt_clear;
    logic [CW-1:0] fwd_pkt_cnt;
    logic [CW-1:0] drop_pkt_cnt;
    logic [2:0]    fifo_level;

    axi_stream_vnp4_if s_if ();
    axi_stream_if      pf_if   [NPF] ();
    axi_stream_if      cmac_if [NCM] ();

    egress_pkt_switch #(
        .NUM_PHYS_FUNC(NPF), .NUM_CMAC_PORT(NCM), .FIFO_DEPTH(DEPTH), .CNT_W(CW)
    ) dut (
        .aclk(aclk), .areset(areset), .s_axis(s_if), .m_axis_pf(pf_if), .m_axis_cmac(cmac_if),
        .cnt_clear(cnt_clear), .fwd_pkt_cnt(fwd_pkt_cnt), .drop_pkt_cnt(drop_pkt_cnt),
        .fifo_level(fifo_level)
    );

    always #5 aclk = ~aclk;

    // Ports 0..1 are pf[0..1], ports 2..3 are cmac[0..1].
    logic [3:0]  o_valid;
    logic [3:0]  o_last;
    logic [3:0]  o_ready;
    logic [63:0] o_data [4];
    logic [15:0] o_dst  [4];

    for (genvar g = 0; g < 2; g++) begin : g_tap
        assign o_valid[g]     = pf_if[g].valid;
        assign o_last[g]      = pf_if[g].last;
        assign o_data[g]      = pf_if[g].data;
        assign o_dst[g]       = pf_if[g].user_dst;
        assign pf_if[g].ready = o_ready[g];
        assign o_valid[2+g]     = cmac_if[g].valid;
        assign o_last[2+g]      = cmac_if[g].last;
        assign o_data[2+g]      = cmac_if[g].data;
        assign o_dst[2+g]       = cmac_if[g].user_dst;
        assign cmac_if[g].ready = o_ready[2+g];
    end

    typedef struct {
        int          port;
        logic [63:0] data;
        logic        last;
        logic [15:0] dst;
        int          cyc;
    } rec_t;

    rec_t log_q[$];
    int   cyc = 0;
    int   any_valid = 0;
    int   max_level = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always @(posedge aclk) cyc++;

    always @(negedge aclk) begin
        if (!areset) begin
            for (int p = 0; p < 4; p++) begin
                if (o_valid[p]) begin
                    any_valid++;
                    if (o_ready[p]) log_q.push_back('{p, o_data[p], o_last[p], o_dst[p], cyc});
                end
            end
            if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int n_for(input int p);
        int n = 0;
        foreach (log_q[k]) if (log_q[k].port == p) n++;
        return n;
    endfunction

    function automatic rec_t rec_at(input int p, input int n);
        rec_t r;
        int   k = 0;
        r = '{-1, 64'h0, 1'b0, 16'h0, -1};
        foreach (log_q[j]) begin
            if (log_q[j].port == p) begin
                if (k == n) return log_q[j];
                k++;
            end
        end
        return r;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic push(input logic [63:0] d, input logic lst, input logic uv, input logic [1:0] dir,
                        input logic [3:0] dpf, input logic [9:0] dcm, output int acc_cyc);
        s_if.valid             = 1'b1;
        s_if.data              = d;
        s_if.keep              = 8'hFF;
        s_if.last              = lst;
        s_if.user_valid        = uv;
        s_if.user_size         = 16'd64;
        s_if.user_src_pf       = 4'h3;
        s_if.user_dst_pf       = dpf;
        s_if.user_src_cmac     = 10'h2A;
        s_if.user_dst_cmac     = dcm;
        s_if.user_to_direction = dir;
        acc_cyc = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge aclk);
            if (s_if.ready) begin
                acc_cyc = cyc;
                break;
            end
        end
        if (acc_cyc < 0) begin
            s_if.valid = 1'b0;
            check("push_timeout", 64'd0, 64'd1);
        end
        @(posedge aclk);
        #1;
    endtask

    rec_t r;
    int   acc0;
    int   dummy;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        areset = 1'b1;
        cnt_clear = 1'b0;
        o_ready = 4'hF;
        s_if.valid = 1'b0; s_if.data = '0; s_if.keep = '0; s_if.last = 1'b0;
        s_if.user_valid = 1'b0; s_if.user_size = '0; s_if.user_src_pf = '0; s_if.user_dst_pf = '0;
        s_if.user_src_cmac = '0; s_if.user_dst_cmac = '0; s_if.user_to_direction = '0;

        @(negedge aclk);
        check("ready_in_reset", s_if.ready, 1'b0);
        check("valid_in_reset", o_valid, 4'h0);
        @(posedge aclk); #1;
        areset = 1'b0;
        @(negedge aclk);
        check("ready_after_reset", s_if.ready, 1'b1);
        check("valid_after_reset", o_valid, 4'h0);
        check("fwd_reset", fwd_pkt_cnt, 3'd0);
        check("drop_reset", drop_pkt_cnt, 3'd0);
        check("level_reset", fifo_level, 3'd0);
        @(posedge aclk); #1;

        // 3-beat unicast packet to pf[0]
        log_q.delete();
        push(64'hA0, 1'b0, 1'b1, DIR_PF, 4'b0001, 10'h0, acc0);
        push(64'hA1, 1'b0, 1'b1, DIR_PF, 4'b0001, 10'h0, dummy);
        push(64'hA2, 1'b1, 1'b1, DIR_PF, 4'b0001, 10'h0, dummy);
        s_if.valid = 1'b0;
        idle(4);
        check("uni_pf0_beats", n_for(0), 3);
        check("uni_other_beats", n_for(1) + n_for(2) + n_for(3), 0);
        r = rec_at(0, 0);
        check("uni_b0_data", r.data, 64'hA0);
        check("uni_b0_last", r.last, 1'b0);
        check("uni_latency", r.cyc, acc0 + 1);
        r = rec_at(0, 1);
        check("uni_b1_last", r.last, 1'b0);
        r = rec_at(0, 2);
        check("uni_b2_data", r.data, 64'hA2);
        check("uni_b2_last", r.last, 1'b1);
        check("uni_fwd", fwd_pkt_cnt, 3'd1);

        // route lock: later beats carry a different dst_pf
        log_q.delete();
        push(64'hB0, 1'b0, 1'b1, DIR_PF, 4'b0010, 10'h0, dummy);
        push(64'hB1, 1'b0, 1'b1, DIR_PF, 4'b0001, 10'h0, dummy);
        push(64'hB2, 1'b1, 1'b1, DIR_PF, 4'b0001, 10'h0, dummy);
        s_if.valid = 1'b0;
        idle(4);
        check("lock_pf1_beats", n_for(1), 3);
        check("lock_pf0_beats", n_for(0), 0);
        r = rec_at(1, 0);
        check("lock_b0_dst", r.dst, 16'h0002);
        r = rec_at(1, 2);
        check("lock_b2_data", r.data, 64'hB2);
        check("lock_b2_last", r.last, 1'b1);
        check("lock_fwd", fwd_pkt_cnt, 3'd2);

        // multicast pf[0]+cmac[0] with cmac[0] stalled
        log_q.delete();
        o_ready = 4'b1011;
        push(64'hC0, 1'b1, 1'b1, DIR_BOTH, 4'b0001, 10'h001, dummy);
        push(64'hC1, 1'b1, 1'b1, DIR_BOTH, 4'b0001, 10'h001, dummy);
        push(64'hC2, 1'b1, 1'b1, DIR_BOTH, 4'b0001, 10'h001, dummy);
        push(64'hC3, 1'b1, 1'b1, DIR_BOTH, 4'b0001, 10'h001, dummy);
        s_if.valid = 1'b0;
        @(negedge aclk);
        check("mc_level_full", fifo_level, 3'd4);
        check("mc_ready_full", s_if.ready, 1'b0);
        idle(1);
        check("mc_pf0_once", n_for(0), 1);
        check("mc_cmac0_none", n_for(2), 0);
        o_ready = 4'hF;
        idle(8);
        check("mc_pf0_total", n_for(0), 4);
        check("mc_cmac0_total", n_for(2), 4);
        r = rec_at(2, 0);
        check("mc_cmac0_first", r.data, 64'hC0);
        r = rec_at(0, 3);
        check("mc_pf0_last", r.data, 64'hC3);
        check("mc_level_empty", fifo_level, 3'd0);
        check("mc_fwd", fwd_pkt_cnt, 3'd6);

        // beat without user_valid is swallowed
        log_q.delete();
        push(64'hD0, 1'b1, 1'b0, DIR_PF, 4'b0001, 10'h0, dummy);
        s_if.valid = 1'b0;
        @(negedge aclk);
        check("uv0_level", fifo_level, 3'd0);
        idle(2);
        check("uv0_no_out", log_q.size(), 0);

        // empty route: dst_pf bit beyond the PF count
        log_q.delete();
        any_valid = 0;
        push(64'hE0, 1'b0, 1'b1, DIR_PF, 4'b1000, 10'h0, dummy);
        push(64'hE1, 1'b1, 1'b1, DIR_PF, 4'b1000, 10'h0, dummy);
        s_if.valid = 1'b0;
        @(negedge aclk);
        check("drop_level_mid", fifo_level, 3'd1);
        idle(1);
        check("drop_level_end", fifo_level, 3'd0);
        check("drop_cnt", drop_pkt_cnt, 3'd1);
        check("drop_no_valid", any_valid, 0);
        check("drop_fwd_same", fwd_pkt_cnt, 3'd6);

        // cnt_clear coincident with a forwarded last pop
        log_q.delete();
        push(64'hF0, 1'b1, 1'b1, DIR_PF, 4'b0001, 10'h0, dummy);
        s_if.valid = 1'b0;
        cnt_clear = 1'b1;
        idle(1);
        cnt_clear = 1'b0;
        check("clr_fwd", fwd_pkt_cnt, 3'd0);
        check("clr_drop", drop_pkt_cnt, 3'd0);
        check("clr_beat_out", n_for(0), 1);

        // back-to-back single-beat packets, counter saturates at 7
        log_q.delete();
        max_level = 0;
        for (int k = 0; k < 9; k++) begin
            push(64'h100 + 64'(k), 1'b1, 1'b1, DIR_PF, 4'b0001, 10'h0, dummy);
        end
        s_if.valid = 1'b0;
        idle(3);
        check("b2b_beats", n_for(0), 9);
        check("b2b_span", rec_at(0, 8).cyc - rec_at(0, 0).cyc, 8);
        r = rec_at(0, 4);
        check("b2b_b4_data", r.data, 64'h104);
        check("b2b_max_level", max_level, 1);
        check("fwd_saturate", fwd_pkt_cnt, 3'd7);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
